// File: rtl/upc_seq.sv
// rtl/upc_seq.sv - micro-program sequencer with call/return stack and sticky stack error flags.
// Optional breakpoint/halt logic is built when UPC_SEQ_BREAKPOINT_EN is defined.
module upc_seq #(
  parameter int               UPC_W       = 5,
  parameter int               STACK_DEPTH = 4,
  parameter logic [UPC_W-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2:0]                         op_i,
  input  logic                               cond_i,
  input  logic [UPC_W-1:0]                   upc_next_i,
`ifdef UPC_SEQ_BREAKPOINT_EN
  input  logic                               bp_en_i,
  input  logic [UPC_W-1:0]                   bp_addr_i,
  input  logic                               bp_resume_i,
  output logic                               halted_o,
`endif
  output logic [UPC_W-1:0]                   upc_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth_o,
  output logic                               stk_full_o,
  output logic                               stk_empty_o,
  output logic                               ovf_err_o,
  output logic                               unf_err_o,
  output logic                               wrap_o
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_INCR = 3'd0,
    OP_JUMP = 3'd1,
    OP_BRC  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HOLD = 3'd5
  } op_e;

  logic [UPC_W-1:0] upc_q, upc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wrap_q, wrap_d;
  logic             push;
  logic             run;
  logic [UPC_W-1:0] stack_q [STACK_DEPTH];

  logic [UPC_W-1:0] upc_inc;
  logic             upc_max;
  logic             full;
  logic             empty;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;

`ifdef UPC_SEQ_BREAKPOINT_EN
  logic halted_q, halted_d;
  // skip_q suppresses re-halting at the breakpoint we just resumed from until upc moves.
  logic skip_q, skip_d;
  logic bp_hit;
`endif

  assign upc_inc  = upc_q + UPC_W'(1);
  assign upc_max  = &upc_q;
  assign full     = (depth_q == FULL_DEPTH);
  assign empty    = (depth_q == '0);
  assign top_idx  = AW'(depth_q - DW'(1));
  assign push_idx = AW'(depth_q);

  always_comb begin
    upc_d   = upc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wrap_d  = 1'b0;
    push    = 1'b0;
`ifdef UPC_SEQ_BREAKPOINT_EN
    bp_hit   = bp_en_i && (upc_q == bp_addr_i) && !skip_q;
    run      = halted_q ? bp_resume_i : !bp_hit;
    halted_d = halted_q ? !bp_resume_i : bp_hit;
`else
    run = 1'b1;
`endif
    if (run) begin
      case (op_i)
        OP_INCR: begin
          upc_d  = upc_inc;
          wrap_d = upc_max;
        end
        OP_JUMP: upc_d = upc_next_i;
        OP_BRC: begin
          if (cond_i) begin
            upc_d = upc_next_i;
          end else begin
            upc_d  = upc_inc;
            wrap_d = upc_max;
          end
        end
        OP_CALL: begin
          upc_d = upc_next_i;
          if (!full) begin
            push    = 1'b1;
            depth_d = depth_q + DW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            upc_d   = stack_q[top_idx];
            depth_d = depth_q - DW'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
`ifdef UPC_SEQ_BREAKPOINT_EN
    skip_d = (skip_q || (halted_q && bp_resume_i)) && (upc_d == upc_q);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_q    <= RESET_ADDR;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      wrap_q   <= 1'b0;
`ifdef UPC_SEQ_BREAKPOINT_EN
      halted_q <= 1'b0;
      skip_q   <= 1'b0;
`endif
    end else begin
      upc_q    <= upc_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      wrap_q   <= wrap_d;
`ifdef UPC_SEQ_BREAKPOINT_EN
      halted_q <= halted_d;
      skip_q   <= skip_d;
`endif
    end
  end

  // Stack contents need no reset; only depth_q decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= upc_inc;
    end
  end

  assign upc_o       = upc_q;
  assign depth_o     = depth_q;
  assign stk_full_o  = full;
  assign stk_empty_o = empty;
  assign ovf_err_o   = ovf_q;
  assign unf_err_o   = unf_q;
  assign wrap_o      = wrap_q;
`ifdef UPC_SEQ_BREAKPOINT_EN
  assign halted_o    = halted_q;
`endif

endmodule
